ep2_port_demux: RTL and testbench

- Sits between the FX2 interface EP2 byte stream and the four EP2->RAM tracking FIFOs (one per converter slot).
- Parses a framed host stream: a port header, then a 16-bit length, then payload.
- Steers each payload byte to the selected port's FIFO write strobe.
- Applies backpressure from each FIFO's fill level, computed from its address pair, so no FIFO is ever overrun.

---
 rtl/ep2_port_demux.sv | 147 ++++++++++++++
 tb/tb_ep2_port_demux.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ep2_port_demux.sv
// EP2 framed-stream demux: parses port header + 16-bit length, steers payload to per-port FIFO strobes.
// Optional macro EP2_PORT_DEMUX_STATS_EN adds per-port 32-bit write byte counters (port_byte_counts).
`timescale 1ns/1ps
module ep2_port_demux #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned FIFO_ADDR_W = 11,
  parameter int unsigned MAX_LEN     = 32'h0000_FFFF
) (
  input  logic                             ep2_port_clk,
  input  logic                             reset,
  input  logic [7:0]                       in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_PORTS*FIFO_ADDR_W-1:0] fifo_addr_ins,
  input  logic [NUM_PORTS*FIFO_ADDR_W-1:0] fifo_addr_outs,
  output logic [7:0]                       ep2_port_data,
  output logic [NUM_PORTS-1:0]             ep2_port_write,
  output logic                             busy,
  output logic                             err_frame,
  output logic [15:0]                      drop_count
`ifdef EP2_PORT_DEMUX_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]          port_byte_counts
`endif
);
  localparam int unsigned PORT_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {ST_HDR, ST_LEN_HI, ST_LEN_LO, ST_PAYLOAD} state_t;

  state_t                 state_q;
  logic [PORT_W-1:0]      port_q;
  logic [7:0]             len_hi_q;
  logic [15:0]            remaining_q;
  logic                   drop_q;
  logic [7:0]             data_q;
  logic [NUM_PORTS-1:0]   write_q;
  logic                   err_q;
  logic [15:0]            drop_cnt_q;

  logic [FIFO_ADDR_W-1:0] free_w [NUM_PORTS];
  logic [15:0]            len_d;
  logic                   hdr_bad;
  logic                   len_bad;
  logic                   accept;

  // free = depth - 1 - used, which in FIFO_ADDR_W-bit arithmetic is simply ~used
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      free_w[p] = ~(fifo_addr_ins[p*FIFO_ADDR_W +: FIFO_ADDR_W]
                    - fifo_addr_outs[p*FIFO_ADDR_W +: FIFO_ADDR_W]);
    end
  end

  always_comb begin
    in_ready = 1'b1;
    if (state_q == ST_PAYLOAD && !drop_q) begin
      in_ready = (free_w[port_q] >= FIFO_ADDR_W'(2));
    end
  end

  assign accept  = in_valid && in_ready;
  assign hdr_bad = |in_data[7:PORT_W];
  assign len_d   = {len_hi_q, in_data};
  assign len_bad = 32'(len_d) > MAX_LEN;

  always_ff @(posedge ep2_port_clk) begin
    if (reset) begin
      state_q     <= ST_HDR;
      port_q      <= '0;
      len_hi_q    <= '0;
      remaining_q <= '0;
      drop_q      <= 1'b0;
      data_q      <= '0;
      write_q     <= '0;
      err_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      write_q <= '0;
      err_q   <= 1'b0;
      if (accept) begin
        case (state_q)
          ST_HDR: begin
            port_q  <= in_data[PORT_W-1:0];
            drop_q  <= hdr_bad;
            err_q   <= hdr_bad;
            state_q <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            len_hi_q <= in_data;
            state_q  <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            remaining_q <= len_d;
            if (len_d == 16'd0) begin
              state_q <= ST_HDR;
              drop_q  <= 1'b0;
            end else begin
              state_q <= ST_PAYLOAD;
              if (len_bad) begin
                err_q  <= 1'b1;
                drop_q <= 1'b1;
              end
            end
          end
          ST_PAYLOAD: begin
            remaining_q <= remaining_q - 16'd1;
            if (drop_q) begin
              if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end else begin
              data_q  <= in_data;
              write_q <= NUM_PORTS'(1) << port_q;
            end
            if (remaining_q == 16'd1) begin
              state_q <= ST_HDR;
              drop_q  <= 1'b0;
            end
          end
          default: state_q <= ST_HDR;
        endcase
      end
    end
  end

  assign ep2_port_data  = data_q;
  assign ep2_port_write = write_q;
  assign busy           = (state_q != ST_HDR);
  assign err_frame      = err_q;
  assign drop_count     = drop_cnt_q;

`ifdef EP2_PORT_DEMUX_STATS_EN
  logic [31:0] byte_cnt_q [NUM_PORTS];

  always_ff @(posedge ep2_port_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (reset)           byte_cnt_q[p] <= '0;
      else if (write_q[p]) byte_cnt_q[p] <= byte_cnt_q[p] + 32'd1;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_byte_counts[p*32 +: 32] = byte_cnt_q[p];
    end
  end
`endif

endmodule

// File: tb/tb_ep2_port_demux.sv
// Scoreboard bench for ep2_port_demux: frame-level model pushes expected strobes, negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_ep2_port_demux;
  localparam int NP = 4;
  localparam int AW = 11;

  logic             ep2_port_clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NP*AW-1:0] fifo_addr_ins;
  logic [NP*AW-1:0] fifo_addr_outs;
  logic [7:0]       ep2_port_data;
  logic [NP-1:0]    ep2_port_write;
  logic             busy;
  logic             err_frame;
  logic [15:0]      drop_count;
`ifdef EP2_PORT_DEMUX_STATS_EN
  logic [NP*32-1:0] port_byte_counts;
`endif

  ep2_port_demux dut (
    .ep2_port_clk   (ep2_port_clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .fifo_addr_ins  (fifo_addr_ins),
    .fifo_addr_outs (fifo_addr_outs),
    .ep2_port_data  (ep2_port_data),
    .ep2_port_write (ep2_port_write),
    .busy           (busy),
    .err_frame      (err_frame),
    .drop_count     (drop_count)
`ifdef EP2_PORT_DEMUX_STATS_EN
    ,
    .port_byte_counts (port_byte_counts)
`endif
  );

  always #5 ep2_port_clk = ~ep2_port_clk;

  int cyc = 0;
  always @(posedge ep2_port_clk) cyc <= cyc + 1;

  // bench-owned FIFO pointers: writes advance a_in, the drain process advances a_out
  logic [AW-1:0] a_in  [NP];
  logic [AW-1:0] a_out [NP];
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      fifo_addr_ins[p*AW +: AW]  = a_in[p];
      fifo_addr_outs[p*AW +: AW] = a_out[p];
    end
  end

  typedef struct {
    int         port;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  logic [7:0] pay_q[$];
  int         total = 0;
  int         bad = 0;
  int         err_seen = 0;
  int         exp_err = 0;
  int         exp_drop = 0;
  int         wr_cnt [NP];
  bit         drain_en = 1'b0;
  logic [AW-1:0] used_w;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge ep2_port_clk) begin
    if (!reset) begin
      if (err_frame) err_seen++;
      if (ep2_port_write != '0) begin
        if (sbq.size() == 0) begin
          check("unexpected_write", 32'(ep2_port_write), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          check("strobe", 32'(ep2_port_write), 32'd1 << mon_e.port);
          check("data", 32'(ep2_port_data), 32'(mon_e.data));
          check("latency", cyc, mon_e.cyc);
        end
        for (int p = 0; p < NP; p++) begin
          if (ep2_port_write[p]) begin
            used_w = a_in[p] - a_out[p];
            check("no_overrun", 32'(used_w != AW'(2047)), 32'd1);
            a_in[p] = a_in[p] + AW'(1);
            wr_cnt[p]++;
          end
        end
      end
    end
  end

  always @(negedge ep2_port_clk) begin
    if (drain_en) begin
      for (int p = 0; p < NP; p++) begin
        if (a_out[p] != a_in[p] && $urandom_range(0, 3) == 0) a_out[p] = a_out[p] + AW'(1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit wr, input int port, input int gap,
                           output int stalls);
    stalls = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge ep2_port_clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge ep2_port_clk);
      #1;
      if (in_ready) begin
        if (wr) sbq.push_back('{port, b, cyc + 1});
        @(posedge ep2_port_clk);
        #1;
        break;
      end
      stalls++;
      if (stalls > 400) begin
        check("accept_timeout", 32'(stalls), 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  function automatic int pick_gap(input bit rnd);
    if (!rnd) return 0;
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  task automatic send_packet(input logic [7:0] hdr, input logic [15:0] len, input bit rnd,
                             output int stalls);
    bit         drop = (hdr[7:2] != 6'd0);
    int         port = int'(hdr[1:0]);
    int         st;
    logic [7:0] pl;
    stalls = 0;
    if (drop) exp_err++;
    send_byte(hdr, 1'b0, 0, pick_gap(rnd), st);       stalls += st;
    send_byte(len[15:8], 1'b0, 0, pick_gap(rnd), st); stalls += st;
    send_byte(len[7:0], 1'b0, 0, pick_gap(rnd), st);  stalls += st;
    for (int i = 0; i < int'(len); i++) begin
      pl = (i < pay_q.size()) ? pay_q[i] : 8'($urandom);
      send_byte(pl, !drop, port, pick_gap(rnd), st);
      stalls += st;
      if (drop && exp_drop < 65535) exp_drop++;
    end
    pay_q.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge ep2_port_clk);
    @(negedge ep2_port_clk);
    check("rst_data", 32'(ep2_port_data), 32'd0);
    check("rst_write", 32'(ep2_port_write), 32'd0);
    check("rst_err", 32'(err_frame), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge ep2_port_clk);
    #1;
    reset    = 1'b0;
    exp_drop = 0;
    sbq.delete();
  endtask

  int st;
  int st3;
  int base;
  int base_err;
  int sum_before;
  int u;
  int plen;
  logic [7:0] hdr;

  initial begin
    for (int p = 0; p < NP; p++) begin
      a_in[p]   = '0;
      a_out[p]  = '0;
      wr_cnt[p] = 0;
    end
    @(posedge ep2_port_clk);
    #1;
    do_reset();
    check("idle_ready", 32'(in_ready), 32'd1);

    // single packet, in_valid held high
    base = wr_cnt[2];
    pay_q = '{8'hAA, 8'hBB, 8'hCC};
    send_packet(8'h02, 16'd3, 1'b0, st);
    in_valid = 1'b0;
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_stalls", 32'(st), 32'd0);
    repeat (3) @(posedge ep2_port_clk);
    #1;
    check("t1_writes", 32'(wr_cnt[2] - base), 32'd3);

    // back-to-back packets
    pay_q = '{8'h11};
    send_packet(8'h01, 16'd1, 1'b0, st);
    u = st;
    pay_q = '{8'h33, 8'h44};
    send_packet(8'h03, 16'd2, 1'b0, st);
    in_valid = 1'b0;
    check("t2_no_stall", 32'(u + st), 32'd0);
    repeat (3) @(posedge ep2_port_clk);
    #1;
    check("t2_drained", 32'(sbq.size()), 32'd0);

    // nearly-full port 0 must stall until the reader advances
    a_in[0]  = 11'h7FE;
    a_out[0] = 11'h000;
    base = wr_cnt[0];
    fork
      send_packet(8'h00, 16'd4, 1'b0, st3);
      begin
        repeat (12) @(posedge ep2_port_clk);
        #1;
        check("t3_stalled_ready", 32'(in_ready), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_no_write_yet", 32'(wr_cnt[0] - base), 32'd0);
        a_out[0] = 11'h004;
      end
    join
    in_valid = 1'b0;
    repeat (3) @(posedge ep2_port_clk);
    #1;
    check("t3_writes", 32'(wr_cnt[0] - base), 32'd4);

    // pointer wrap: used = 19, no stall expected
    a_in[0]  = 11'h003;
    a_out[0] = 11'h7F0;
    base = wr_cnt[0];
    send_packet(8'h00, 16'd10, 1'b0, st);
    in_valid = 1'b0;
    check("t4_no_stall", 32'(st), 32'd0);
    repeat (3) @(posedge ep2_port_clk);
    #1;
    check("t4_writes", 32'(wr_cnt[0] - base), 32'd10);

    // bad header: dropped payload, then a normal packet
    base_err   = err_seen;
    sum_before = wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3];
    send_packet(8'h85, 16'd5, 1'b0, st);
    in_valid = 1'b0;
    repeat (3) @(posedge ep2_port_clk);
    #1;
    check("t5_err_pulses", 32'(err_seen - base_err), 32'd1);
    check("t5_drop_count", 32'(drop_count), 32'(exp_drop));
    check("t5_no_writes", 32'(wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3] - sum_before), 32'd0);
    base = wr_cnt[3];
    send_packet(8'h03, 16'd2, 1'b0, st);
    in_valid = 1'b0;
    repeat (3) @(posedge ep2_port_clk);
    #1;
    check("t5_next_pkt", 32'(wr_cnt[3] - base), 32'd2);

    // reset mid-packet
    send_byte(8'h00, 1'b0, 0, 0, st);
    send_byte(8'h00, 1'b0, 0, 0, st);
    send_byte(8'h06, 1'b0, 0, 0, st);
    send_byte(8'h5A, 1'b1, 0, 0, st);
    send_byte(8'hA5, 1'b1, 0, 0, st);
    in_valid = 1'b0;
    repeat (3) @(posedge ep2_port_clk);
    #1;
    check("t6_pre_reset_drained", 32'(sbq.size()), 32'd0);
    do_reset();
    base = wr_cnt[1];
    pay_q = '{8'h77};
    send_packet(8'h01, 16'd1, 1'b0, st);
    in_valid = 1'b0;
    repeat (3) @(posedge ep2_port_clk);
    #1;
    check("t6_port1_after_reset", 32'(wr_cnt[1] - base), 32'd1);

    // randomized traffic with a live reader and random fill levels
    for (int p = 0; p < NP; p++) begin
      u = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 100)) : int'($urandom_range(2040, 2047));
      a_out[p] = AW'($urandom);
      a_in[p]  = a_out[p] + AW'(u);
    end
    drain_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      hdr = {6'd0, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) hdr[7:2] = 6'($urandom_range(1, 63));
      plen = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
      send_packet(hdr, 16'(plen), 1'b1, st);
    end
    in_valid = 1'b0;
    for (int w = 0; w < 2000 && sbq.size() != 0; w++) @(posedge ep2_port_clk);
    repeat (3) @(posedge ep2_port_clk);
    #1;
    drain_en = 1'b0;
    check("rnd_drained", 32'(sbq.size()), 32'd0);
    check("rnd_drop_count", 32'(drop_count), 32'(exp_drop));
    check("rnd_err_count", 32'(err_seen), 32'(exp_err));
    check("rnd_idle_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
